// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy controller.
package mem_copy_pkg;

  localparam int unsigned AwDefault = 8;
  localparam int unsigned DwDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/mem_copy_ctrl.sv
// Byte-wise memory copy engine sharing one memory port with a core that always has priority.
// Optional fill mode (write a constant, no reads) enabled by defining MEM_COPY_FILL_EN.
module mem_copy_ctrl
  import mem_copy_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic          core_req,
  input  logic          core_wr_en,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_dat_in,
`ifdef MEM_COPY_FILL_EN
  input  logic          fill_mode,
  input  logic [DW-1:0] fill_val,
`endif
  output logic [DW-1:0] core_dat_out,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_dat_out,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;

  logic          start_fill;
  logic          fill_active;
  logic [DW-1:0] wr_data;

`ifdef MEM_COPY_FILL_EN
  logic          fill_q;
  logic [DW-1:0] fill_val_q;

  // Fill settings are captured on the same edge that accepts the request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (state_q == StIdle && start && !core_req) begin
      fill_q     <= fill_mode;
      fill_val_q <= fill_val;
    end
  end

  assign start_fill  = fill_mode;
  assign fill_active = fill_q;
  assign wr_data     = fill_q ? fill_val_q : buf_q;
`else
  assign start_fill  = 1'b0;
  assign fill_active = 1'b0;
  assign wr_data     = buf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    mem_addr   = '0;
    mem_dat_in = '0;
    mem_wr_en  = 1'b0;

    if (core_req) begin
      // Core owns the port; the engine stalls except that DONE never waits.
      mem_addr   = core_addr;
      mem_dat_in = core_dat_in;
      mem_wr_en  = core_wr_en;
      if (state_q == StDone) state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_d = src_addr;
            dst_d = dst_addr;
            cnt_d = len;
            if (len == '0)      state_d = StDone;
            else if (start_fill) state_d = StWr;
            else                state_d = StRd;
          end
        end
        StRd: begin
          mem_addr = src_q;
          buf_d    = mem_dat_out;
          state_d  = StWr;
        end
        StWr: begin
          mem_addr   = dst_q;
          mem_dat_in = wr_data;
          // Gate with reset so an abort can never issue one last write.
          mem_wr_en  = rst_n;
          src_d      = src_q + AW'(1);
          dst_d      = dst_q + AW'(1);
          cnt_d      = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) state_d = StDone;
          else if (fill_active) state_d = StWr;
          else                  state_d = StRd;
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign core_dat_out = mem_dat_out;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Directed self-checking bench for mem_copy_ctrl with a behavioural 256-byte memory.
module tb_mem_copy_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] src_addr, dst_addr, len;
  logic       core_req, core_wr_en;
  logic [7:0] core_addr, core_dat_in;
  logic [7:0] core_dat_out, mem_addr, mem_dat_in, mem_dat_out;
  logic       mem_wr_en, busy, done;
`ifdef MEM_COPY_FILL_EN
  logic       fill_mode;
  logic [7:0] fill_val;
`endif

  logic [7:0] mem [256];
  logic       mem_init;
  int         wr_cnt = 0;
  int         checks = 0;
  int         failures = 0;
  int         lat;
  int         wr_before;

  always #5 clk = ~clk;

  mem_copy_ctrl #(.AW(8), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .core_req     (core_req),
    .core_wr_en   (core_wr_en),
    .core_addr    (core_addr),
    .core_dat_in  (core_dat_in),
`ifdef MEM_COPY_FILL_EN
    .fill_mode    (fill_mode),
    .fill_val     (fill_val),
`endif
    .core_dat_out (core_dat_out),
    .mem_addr     (mem_addr),
    .mem_dat_in   (mem_dat_in),
    .mem_wr_en    (mem_wr_en),
    .mem_dat_out  (mem_dat_out),
    .busy         (busy),
    .done         (done)
  );

  // Memory powers up with mem[i] = i ^ 0x5A.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_wr_en === 1'b1) begin
      mem[mem_addr] <= mem_dat_in;
    end
  end

  always @(posedge clk) if (mem_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

  assign mem_dat_out = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    core_req = 1'b1; core_wr_en = 1'b1; core_addr = a; core_dat_in = d;
    @(posedge clk);
    #1 core_req = 1'b0; core_wr_en = 1'b0;
  endtask

  // Issues a request and returns how many cycles after the start edge done is first seen.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int core_at, input int core_n, input int restart_at,
                          input logic fmode, input logic [7:0] fval, output int cyc);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
`ifdef MEM_COPY_FILL_EN
    fill_mode = fmode; fill_val = fval;
`else
    if (fmode) $display("note: fill request ignored in copy-only build (val %0h)", fval);
`endif
    @(posedge clk);
    #1;
    start = 1'b0; src_addr = 8'h00; dst_addr = 8'h90; len = 8'h02;
`ifdef MEM_COPY_FILL_EN
    fill_mode = 1'b1; fill_val = 8'hFF;
`endif
    cyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
      core_req    = (n >= core_at) && (n < core_at + core_n);
      core_wr_en  = core_req;
      core_addr   = 8'h20;
      core_dat_in = 8'h55;
      start       = (n == restart_at);
    end
    core_req = 1'b0; core_wr_en = 1'b0; start = 1'b0;
`ifdef MEM_COPY_FILL_EN
    fill_mode = 1'b0;
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    core_req = 1'b0; core_wr_en = 1'b0; core_addr = '0; core_dat_in = '0;
`ifdef MEM_COPY_FILL_EN
    fill_mode = 1'b0; fill_val = '0;
`endif
    mem_init = 1'b1;
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("idle_wr_en", 32'(mem_wr_en), 32'h0);
    check("idle_addr", 32'(mem_addr), 32'h0);
    check("idle_dat_in", 32'(mem_dat_in), 32'h0);

    // Core pass-through while reset is held.
    core_req = 1'b1; core_wr_en = 1'b1; core_addr = 8'h30; core_dat_in = 8'h77;
    #1;
    check("rst_core_addr", 32'(mem_addr), 32'h30);
    check("rst_core_wr_en", 32'(mem_wr_en), 32'h1);
    check("rst_core_dat_in", 32'(mem_dat_in), 32'h77);
    @(posedge clk);
    #1 core_wr_en = 1'b0;
    #1 check("core_dat_out", 32'(core_dat_out), 32'h77);
    core_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    core_write(8'h10, 8'hA1);
    core_write(8'h11, 8'hB2);
    core_write(8'h12, 8'hC3);
    core_write(8'h13, 8'hD4);

    // Basic copy; a start pulse mid-copy must be ignored.
    run_copy(8'h10, 8'h80, 8'd4, 0, 0, 4, 1'b0, 8'h00, lat);
    check("copy_lat", 32'(lat), 32'd9);
    check("copy_80", 32'(mem[8'h80]), 32'hA1);
    check("copy_81", 32'(mem[8'h81]), 32'hB2);
    check("copy_82", 32'(mem[8'h82]), 32'hC3);
    check("copy_83", 32'(mem[8'h83]), 32'hD4);
    check("restart_ignored", 32'(mem[8'h90]), 32'hCA);

    // Core steals the port for three cycles mid-copy.
    run_copy(8'h10, 8'hC0, 8'd4, 3, 3, 0, 1'b0, 8'h00, lat);
    check("stall_lat", 32'(lat), 32'd12);
    check("stall_core_wr", 32'(mem[8'h20]), 32'h55);
    check("stall_c0", 32'(mem[8'hC0]), 32'hA1);
    check("stall_c1", 32'(mem[8'hC1]), 32'hB2);
    check("stall_c2", 32'(mem[8'hC2]), 32'hC3);
    check("stall_c3", 32'(mem[8'hC3]), 32'hD4);

    // Source pointer wraps FF -> 00.
    run_copy(8'hFE, 8'h40, 8'd4, 0, 0, 0, 1'b0, 8'h00, lat);
    check("wrap_lat", 32'(lat), 32'd9);
    check("wrap_40", 32'(mem[8'h40]), 32'hA4);
    check("wrap_41", 32'(mem[8'h41]), 32'hA5);
    check("wrap_42", 32'(mem[8'h42]), 32'h5A);
    check("wrap_43", 32'(mem[8'h43]), 32'h5B);

    // Zero-length request.
    wr_before = wr_cnt;
    run_copy(8'h10, 8'h50, 8'd0, 0, 0, 0, 1'b0, 8'h00, lat);
    check("len0_lat", 32'(lat), 32'd1);
    check("len0_no_wr", 32'(wr_cnt - wr_before), 32'd0);

    // Overlapping forward copy replicates the first byte.
    run_copy(8'h10, 8'h11, 8'd3, 0, 0, 0, 1'b0, 8'h00, lat);
    check("ovl_lat", 32'(lat), 32'd7);
    check("ovl_11", 32'(mem[8'h11]), 32'hA1);
    check("ovl_12", 32'(mem[8'h12]), 32'hA1);
    check("ovl_13", 32'(mem[8'h13]), 32'hA1);

    // Abort a len=8 copy right after its second write.
    wr_before = wr_cnt;
    @(negedge clk);
    src_addr = 8'h60; dst_addr = 8'hA0; len = 8'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    check("abort_busy_before", 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_wr_cnt", 32'(wr_cnt - wr_before), 32'd2);
    check("abort_a0", 32'(mem[8'hA0]), 32'h3A);
    check("abort_a1", 32'(mem[8'hA1]), 32'h3B);
    check("abort_a2", 32'(mem[8'hA2]), 32'hF8);
    check("abort_a7", 32'(mem[8'hA7]), 32'hFD);

`ifdef MEM_COPY_FILL_EN
    run_copy(8'h33, 8'h00, 8'd16, 0, 0, 0, 1'b1, 8'h00, lat);
    check("fill_lat", 32'(lat), 32'd17);
    for (int i = 0; i < 16; i++) check("fill_byte", 32'(mem[i]), 32'h0);
    check("fill_edge", 32'(mem[8'h10]), 32'hA1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
